io_out_port: RTL and testbench

//   Output-side I/O port on the processor's external byte bus. Consumes bus_out/hs_out under a

---
 rtl/io_out_port_if.sv | 35 +++
 rtl/io_out_port.sv | 133 +++++++++++++
 tb/tb_io_out_port.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/io_out_port_if.sv
// Bus bundle for io_out_port: processor-side byte handshake, interrupt,
// device-side FIFO drain and the occupancy / debug taps.
//
// Handshake semantics on this bundle:
//   Processor side is four-phase: the processor raises hs_out with bus_out
//   stable, the port raises hs_in once the byte is captured, the processor
//   drops hs_out, and the port drops hs_in. Device side is strict
//   valid/ready: dev_data transfers on every rising edge where dev_valid and
//   dev_ready are both 1. dev_valid never depends on dev_ready.
//   dev_data and dev_valid stay stable until that transfer happens.
interface io_out_port_if #(
  parameter int AW = 3
) ();
  logic [7:0]  bus_out;
  logic        hs_out;
  logic        hs_in;
  logic        ext_int;
  logic [7:0]  dev_data;
  logic        dev_valid;
  logic        dev_ready;
  logic [AW:0] level;
  logic [1:0]  fsm_state;   // debug tap: 0=ARM, 1=IDLE, 2=ACK

  // The port itself
  modport slave (
    input  bus_out, hs_out, dev_ready,
    output hs_in, ext_int, dev_data, dev_valid, level, fsm_state
  );

  // Processor plus device (the environment around the port)
  modport master (
    output bus_out, hs_out, dev_ready,
    input  hs_in, ext_int, dev_data, dev_valid, level, fsm_state
  );
endinterface

// File: rtl/io_out_port.sv
// io_out_port: output-side I/O port on the processor byte bus.
// Captures bytes from a four-phase handshake into a first-word-fall-through
// FIFO, drains them to a device over valid/ready, and pulses ext_int when
// the occupancy climbs to the high-water mark.
// The interface instance must use the same AW as this module.
module io_out_port #(
  parameter int DEPTH = 8,   // power of two, >= 2
  parameter int AW    = 3,   // log2(DEPTH)
  parameter int HWM   = 6    // 1..DEPTH
) (
  input  logic          g_clk,
  input  logic          g_clr,
  io_out_port_if.slave  bus
);

  typedef enum logic [1:0] {
    ARM  = 2'd0,   // wait for hs_out low so a request held over reset is ignored
    IDLE = 2'd1,   // wait for a request
    ACK  = 2'd2    // byte captured, hold hs_in until hs_out drops
  } state_t;

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] HWM_LVL  = (AW+1)'(HWM);
  localparam logic [AW:0] HWM_PRE  = (AW+1)'(HWM - 1);

  state_t          state;
  state_t          state_nxt;
  logic            hs_in_q;
  logic            hs_in_nxt;
  logic            ext_int_q;

  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     level;
  logic [AW:0]     level_nxt;

  logic            full;
  logic            pop;
  logic            push;

  // FIFO status; a pop in the same cycle frees a slot for a capture
  assign full = (level == FULL_LVL);
  assign pop  = (level != '0) && bus.dev_ready;

  // Handshake FSM next state, acknowledge and push decision
  always_comb begin
    state_nxt = state;
    hs_in_nxt = 1'b0;
    push      = 1'b0;
    case (state)
      ARM: begin
        if (!bus.hs_out) begin
          state_nxt = IDLE;
        end
      end
      IDLE: begin
        if (bus.hs_out && (!full || pop)) begin
          push      = 1'b1;
          hs_in_nxt = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK: begin
        hs_in_nxt = 1'b1;
        if (!bus.hs_out) begin
          hs_in_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = ARM;
      end
    endcase
  end

  // Handshake FSM state and acknowledge registers
  always_ff @(posedge g_clk or posedge g_clr) begin
    if (g_clr) begin
      state   <= ARM;
      hs_in_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      hs_in_q <= hs_in_nxt;
    end
  end

  // Occupancy after this edge; push and pop together cancel out
  always_comb begin
    level_nxt = level;
    if (push && !pop) begin
      level_nxt = level + 1'b1;
    end else if (pop && !push) begin
      level_nxt = level - 1'b1;
    end
  end

  // FIFO pointers, occupancy and the high-water interrupt
  always_ff @(posedge g_clk or posedge g_clr) begin
    if (g_clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      ext_int_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      level     <= level_nxt;
      // Only an upward crossing fires, so the pulse re-arms once level
      // has dropped below HWM and climbs back.
      ext_int_q <= (level == HWM_PRE) && (level_nxt == HWM_LVL);
    end
  end

  // FIFO storage; contents need no reset, occupancy guards every read
  always_ff @(posedge g_clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.bus_out;
    end
  end

  assign bus.hs_in     = hs_in_q;
  assign bus.ext_int   = ext_int_q;
  assign bus.dev_data  = mem[rd_ptr];
  assign bus.dev_valid = (level != '0);
  assign bus.level     = level;
  assign bus.fsm_state = state;

endmodule

// File: tb/tb_io_out_port.sv
// Testbench for io_out_port: a vector table for single-byte transfers and
// simultaneous push/pop across the pointer wrap, followed by hand-written
// sequences for fill/stall/drain, high-water re-arm and reset mid-handshake.
module tb_io_out_port;

  logic g_clk;
  logic g_clr;

  io_out_port_if #(.AW(3)) bus ();

  io_out_port #(.DEPTH(8), .AW(3), .HWM(6)) dut (
    .g_clk (g_clk),
    .g_clr (g_clr),
    .bus   (bus.slave)
  );

  // Clock and watchdog
  initial begin
    g_clk = 1'b0;
    forever #5 g_clk = ~g_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic       hs_out;
    logic [7:0] bus_out;
    logic       dev_ready;
    logic       exp_hs_in;
    logic       exp_valid;
    logic [3:0] exp_level;
    logic       chk_data;
    logic [7:0] exp_data;
    logic       exp_int;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];
  int         n_cmp;
  int         n_bad;
  int         int_cnt;

  // Comparison with failure report
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock, then sample 1ns after the edge; counts interrupt cycles
  task automatic step();
    @(posedge g_clk);
    #1;
    if (bus.ext_int === 1'b1) int_cnt++;
  endtask

  task automatic add(input logic hs, input logic [7:0] b, input logic rdy,
                     input logic ehs, input logic ev, input logic [3:0] el,
                     input logic cd, input logic [7:0] ed, input logic ei);
    vec_t v;
    v.hs_out = hs; v.bus_out = b; v.dev_ready = rdy;
    v.exp_hs_in = ehs; v.exp_valid = ev; v.exp_level = el;
    v.chk_data = cd; v.exp_data = ed; v.exp_int = ei;
    vecs.push_back(v);
  endtask

  // Full four-phase handshake; reports ext_int seen right after the push edge
  task automatic handshake(input logic [7:0] b, output logic int_seen);
    bus.bus_out = b;
    bus.hs_out  = 1'b1;
    step();
    chk("hs_rise", bus.hs_in, 1'b1);
    int_seen = bus.ext_int;
    bus.hs_out = 1'b0;
    step();
    chk("hs_fall", bus.hs_in, 1'b0);
  endtask

  // One-cycle device accept
  task automatic pop_one();
    bus.dev_ready = 1'b1;
    step();
    bus.dev_ready = 1'b0;
    chk("pop_int", bus.ext_int, 1'b0);
  endtask

  initial begin
    logic seen;
    int   n;
    n_cmp   = 0;
    n_bad   = 0;
    int_cnt = 0;

    // Test 1: single byte, then drain it
    add(1, 8'hA5, 0,  1, 1, 4'd1, 1, 8'hA5, 0);
    add(0, 8'h00, 0,  0, 1, 4'd1, 1, 8'hA5, 0);
    add(0, 8'h00, 1,  0, 0, 4'd0, 0, 8'h00, 0);
    // Test 4: level 3, then push+pop together across the wr_ptr 7->0 wrap
    add(1, 8'h11, 0,  1, 1, 4'd1, 1, 8'h11, 0);
    add(0, 8'h00, 0,  0, 1, 4'd1, 1, 8'h11, 0);
    add(1, 8'h22, 0,  1, 1, 4'd2, 1, 8'h11, 0);
    add(0, 8'h00, 0,  0, 1, 4'd2, 1, 8'h11, 0);
    add(1, 8'h33, 0,  1, 1, 4'd3, 1, 8'h11, 0);
    add(0, 8'h00, 0,  0, 1, 4'd3, 1, 8'h11, 0);
    add(1, 8'h44, 1,  1, 1, 4'd3, 1, 8'h22, 0);
    add(0, 8'h00, 0,  0, 1, 4'd3, 1, 8'h22, 0);
    add(1, 8'h55, 1,  1, 1, 4'd3, 1, 8'h33, 0);
    add(0, 8'h00, 0,  0, 1, 4'd3, 1, 8'h33, 0);
    add(1, 8'h66, 1,  1, 1, 4'd3, 1, 8'h44, 0);
    add(0, 8'h00, 0,  0, 1, 4'd3, 1, 8'h44, 0);
    add(1, 8'h77, 1,  1, 1, 4'd3, 1, 8'h55, 0);
    add(0, 8'h00, 0,  0, 1, 4'd3, 1, 8'h55, 0);
    add(1, 8'h88, 1,  1, 1, 4'd3, 1, 8'h66, 0);
    add(0, 8'h00, 0,  0, 1, 4'd3, 1, 8'h66, 0);
    add(0, 8'h00, 1,  0, 1, 4'd2, 1, 8'h77, 0);
    add(0, 8'h00, 1,  0, 1, 4'd1, 1, 8'h88, 0);
    add(0, 8'h00, 1,  0, 0, 4'd0, 0, 8'h00, 0);

    // Reset
    g_clr         = 1'b1;
    bus.hs_out    = 1'b0;
    bus.bus_out   = 8'h00;
    bus.dev_ready = 1'b0;
    #12;
    g_clr = 1'b0;
    chk("rst_hs_in", bus.hs_in, 1'b0);
    chk("rst_int", bus.ext_int, 1'b0);
    chk("rst_level", bus.level, 4'd0);
    chk("rst_valid", bus.dev_valid, 1'b0);
    chk("rst_state", bus.fsm_state, 2'd0);
    step();
    chk("arm_to_idle", bus.fsm_state, 2'd1);

    // Table
    for (int i = 0; i < vecs.size(); i++) begin
      bus.hs_out    = vecs[i].hs_out;
      bus.bus_out   = vecs[i].bus_out;
      bus.dev_ready = vecs[i].dev_ready;
      step();
      chk($sformatf("v%0d_hs_in", i), bus.hs_in, vecs[i].exp_hs_in);
      chk($sformatf("v%0d_valid", i), bus.dev_valid, vecs[i].exp_valid);
      chk($sformatf("v%0d_level", i), bus.level, vecs[i].exp_level);
      chk($sformatf("v%0d_int", i), bus.ext_int, vecs[i].exp_int);
      if (vecs[i].chk_data) chk($sformatf("v%0d_data", i), bus.dev_data, vecs[i].exp_data);
    end
    bus.dev_ready = 1'b0;

    // Test 2: fill to 8, interrupt once after the 6th push, 9th stalls
    int_cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      handshake(8'(i), seen);
      chk($sformatf("fill%0d_int", i), seen, (i == 6));
      exp_q.push_back(8'(i));
    end
    chk("fill_level", bus.level, 4'd8);
    chk("fill_int_count", int_cnt, 1);
    bus.bus_out = 8'h09;
    bus.hs_out  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_hs_in", bus.hs_in, 1'b0);
      chk("stall_level", bus.level, 4'd8);
    end
    chk("stall_head", bus.dev_data, exp_q[0]);
    bus.dev_ready = 1'b1;
    step();
    bus.dev_ready = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(8'h09);
    chk("accept9_hs_in", bus.hs_in, 1'b1);
    chk("accept9_level", bus.level, 4'd8);
    chk("accept9_head", bus.dev_data, exp_q[0]);
    bus.hs_out = 1'b0;
    step();
    chk("accept9_hs_fall", bus.hs_in, 1'b0);
    chk("full_int_count", int_cnt, 1);

    // Test 3: drain in order, one byte per cycle
    bus.dev_ready = 1'b1;
    n = 0;
    while (bus.dev_valid && exp_q.size() > 0 && n < 20) begin
      chk("drain_data", bus.dev_data, exp_q.pop_front());
      n++;
      step();
    end
    bus.dev_ready = 1'b0;
    chk("drain_count", n, 8);
    chk("drain_q_left", exp_q.size(), 0);
    chk("drain_valid", bus.dev_valid, 1'b0);
    chk("drain_level", bus.level, 4'd0);

    // Test 6: high-water re-arm
    int_cnt = 0;
    for (int i = 1; i <= 6; i++) begin
      handshake(8'(8'h60 + i), seen);
      chk($sformatf("hwm%0d_int", i), seen, (i == 6));
    end
    chk("hwm_level6", bus.level, 4'd6);
    pop_one();
    chk("hwm_level5", bus.level, 4'd5);
    handshake(8'h6F, seen);
    chk("hwm_rearm_int", seen, 1'b1);
    chk("hwm_rearm_count", int_cnt, 2);
    for (int k = 0; k < 2; k++) begin
      handshake(8'h70, seen);
      chk("osc_up_int", seen, 1'b0);
      chk("osc_level7", bus.level, 4'd7);
      pop_one();
      chk("osc_level6", bus.level, 4'd6);
    end
    chk("osc_int_count", int_cnt, 2);

    // Test 5: asynchronous reset while in ACK with hs_out held
    bus.bus_out = 8'hC3;
    bus.hs_out  = 1'b1;
    step();
    chk("pre_rst_hs_in", bus.hs_in, 1'b1);
    g_clr = 1'b1;
    #1;
    chk("async_hs_in", bus.hs_in, 1'b0);
    chk("async_level", bus.level, 4'd0);
    chk("async_valid", bus.dev_valid, 1'b0);
    chk("async_state", bus.fsm_state, 2'd0);
    #2;
    g_clr = 1'b0;
    bus.dev_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("held_hs_in", bus.hs_in, 1'b0);
      chk("held_level", bus.level, 4'd0);
      chk("held_state", bus.fsm_state, 2'd0);
    end
    bus.dev_ready = 1'b0;
    bus.hs_out = 1'b0;
    step();
    chk("rearm_state", bus.fsm_state, 2'd1);
    bus.bus_out = 8'h3C;
    bus.hs_out  = 1'b1;
    step();
    chk("resume_hs_in", bus.hs_in, 1'b1);
    chk("resume_level", bus.level, 4'd1);
    chk("resume_data", bus.dev_data, 8'h3C);
    bus.hs_out = 1'b0;
    step();
    chk("resume_hs_fall", bus.hs_in, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
